// File: rtl/alu_exec.sv
// Y86-64 execute-stage ALU: computes valE, owns the {ZF,SF,OF} condition codes,
// evaluates Cnd for jXX/cmovXX, and holds its result in a one-entry valid/ready buffer.
module alu_exec #(
    parameter int         W        = 64,
    parameter logic [2:0] CC_RESET = 3'b100
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   icode,
    input  logic [3:0]   ifun,
    input  logic [W-1:0] aluA,
    input  logic [W-1:0] aluB,
    input  logic         cc_hold,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] valE,
    output logic         Cnd,
    output logic [3:0]   out_icode,
    output logic         out_err,
    output logic [2:0]   cc_out
);

    localparam logic [3:0] IC_CMOV = 4'd2;
    localparam logic [3:0] IC_OPQ  = 4'd6;
    localparam logic [3:0] IC_JXX  = 4'd7;

    logic         r_valid;
    logic [W-1:0] r_val;
    logic         r_cnd;
    logic [3:0]   r_icode;
    logic         r_err;
    logic [2:0]   r_cc;

    logic [W-1:0] w_sum;
    logic [W-1:0] w_diff;
    logic [W-1:0] w_res;
    logic         w_of;
    logic         w_err;
    logic         w_cnd;
    logic         w_cc_we;
    logic [2:0]   w_cc_next;
    logic         w_accept;
    logic         w_consume;
    logic         w_zf;
    logic         w_lt;

    assign w_sum     = aluB + aluA;
    assign w_diff    = aluB - aluA;
    assign in_ready  = (!r_valid || out_ready) && !rst;
    assign w_accept  = in_valid && in_ready;
    assign w_consume = r_valid && out_ready;

    // Cnd reads the flags as they stand before this cycle's OPq lands
    assign w_zf = r_cc[2];
    assign w_lt = r_cc[1] ^ r_cc[0];

    always_comb begin
        w_res   = '0;
        w_of    = 1'b0;
        w_err   = 1'b0;
        w_cnd   = 1'b0;
        w_cc_we = 1'b0;
        if (icode == IC_OPQ) begin
            case (ifun)
                4'd0: begin
                    w_res = w_sum;
                    w_of  = (aluA[W-1] == aluB[W-1]) && (w_sum[W-1] != aluA[W-1]);
                end
                4'd1: begin
                    w_res = w_diff;
                    w_of  = (aluA[W-1] != aluB[W-1]) && (w_diff[W-1] != aluB[W-1]);
                end
                4'd2:    w_res = aluB & aluA;
                4'd3:    w_res = aluB ^ aluA;
                default: w_err = 1'b1;
            endcase
            w_cc_we = !w_err && !cc_hold;
        end else begin
            w_res = w_sum;
            if (icode == IC_CMOV || icode == IC_JXX) begin
                case (ifun)
                    4'd0:    w_cnd = 1'b1;
                    4'd1:    w_cnd = w_lt || w_zf;
                    4'd2:    w_cnd = w_lt;
                    4'd3:    w_cnd = w_zf;
                    4'd4:    w_cnd = !w_zf;
                    4'd5:    w_cnd = !w_lt;
                    4'd6:    w_cnd = !w_lt && !w_zf;
                    default: w_err = 1'b1;
                endcase
            end
        end
    end

    assign w_cc_next = {(w_res == '0), w_res[W-1], w_of};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_val   <= '0;
            r_cnd   <= 1'b0;
            r_icode <= '0;
            r_err   <= 1'b0;
            r_cc    <= CC_RESET;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_val   <= w_res;
            r_cnd   <= w_cnd;
            r_icode <= icode;
            r_err   <= w_err;
            if (w_cc_we) r_cc <= w_cc_next;
        end else if (w_consume) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign valE      = r_val;
    assign Cnd       = r_cnd;
    assign out_icode = r_icode;
    assign out_err   = r_err;
    assign cc_out    = r_cc;

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execute-stage ALU for the Y86-64 core. Sits directly downstream of the aluA/aluB operand selectors.
- Computes valE from the two operands and owns the condition-code register (ZF, SF, OF).
- Evaluates Cnd for jXX and cmovXX.
- Registers its result behind a single-entry valid/ready output buffer, so it can be used single-cycle (out_ready tied high) or pipelined.

Parameters:
- W, 64, datapath width of aluA, aluB and valE.
- CC_RESET, 3'b100, reset value of the condition codes {ZF,SF,OF}.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands and icode/ifun valid this cycle
- in_ready  output  1  block can accept an operation this cycle
- icode  input  4  instruction code
- ifun  input  4  function code
- aluA  input  W  operand A
- aluB  input  W  operand B
- cc_hold  input  1  when 1, an accepted OPq does not update the condition codes
- out_valid  output  1  valE/Cnd/out_icode/out_err hold a result
- out_ready  input  1  downstream consumes the result this cycle
- valE  output  W  registered ALU result
- Cnd  output  1  registered condition outcome
- out_icode  output  4  icode of the buffered result
- out_err  output  1  buffered operation had an illegal ifun
- cc_out  output  3  current condition codes {ZF,SF,OF}

Behaviour:
- Reset (rst=1 at clock edge):
  - out_valid=0, valE=0, Cnd=0, out_icode=0, out_err=0.
  - cc_out=CC_RESET.
  - rst overrides any accept or consume in the same cycle; an in-flight result is discarded.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; not asserted during rst).
  - Accept = in_valid && in_ready.
  - Consume = out_valid && out_ready.
  - On accept: the buffer loads the new result next edge; out_valid=1.
  - On consume without accept: out_valid=0 next edge; data holds its last value.
  - With out_valid=1 and out_ready=0, the buffer and cc_out are frozen regardless of inputs.
- Latency: 1 cycle from accept to out_valid. Full throughput when out_ready=1.
- Arithmetic: all modulo 2^W.
  - icode=6 (OPq):
    - ifun 0: valE = aluB + aluA
    - ifun 1: valE = aluB - aluA
    - ifun 2: valE = aluB & aluA
    - ifun 3: valE = aluB ^ aluA
    - ifun >3: valE=0, out_err=1, CC not updated.
  - Every other icode: valE = aluB + aluA (covers rrmovq, irmovq, mem address and stack-pointer arithmetic).
- Condition codes:
  - Updated only on accept of icode=6 with legal ifun and cc_hold=0.
  - ZF = (result==0); SF = result[W-1].
  - OF, add: aluA[W-1]==aluB[W-1] && result[W-1]!=aluA[W-1].
  - OF, sub: aluA[W-1]!=aluB[W-1] && result[W-1]!=aluB[W-1].
  - OF, and/xor: 0.
  - New CC visible on cc_out the edge after accept, together with out_valid.
- Cnd: registered on accept and computed from the CC value before any update in that cycle.
  - Applies only to icode=2 or icode=7.
  - ifun 0: 1
  - ifun 1 (le): (SF^OF)|ZF
  - ifun 2 (l): SF^OF
  - ifun 3 (e): ZF
  - ifun 4 (ne): !ZF
  - ifun 5 (ge): !(SF^OF)
  - ifun 6 (g): !(SF^OF)&&!ZF
  - ifun >6: Cnd=0, out_err=1.
  - All other icodes: Cnd=0.
- Back-to-back: an OPq followed next cycle by a jXX sees the OPq's updated CC.
- out_err=0 for all legal operations. out_icode = accepted icode.

Test Plan:
- Reset, then idle: out_valid=0, valE=0, cc_out=3'b100, in_ready=1.
- OPq add: aluA=0x7FFF_FFFF_FFFF_FFFF, aluB=1, icode=6, ifun=0, out_ready=1 -> next cycle valE=0x8000_0000_0000_0000, cc_out={0,1,1}, out_valid=1.
- OPq sub: aluA=5, aluB=5 -> valE=0, cc_out={1,0,0}; then jXX ifun=3 next cycle -> Cnd=1; jXX ifun=4 -> Cnd=0.
- Backpressure: accept addq (aluA=-8, aluB=0x100) with out_ready=0 for 3 cycles while in_valid stays high with new operands -> in_ready=0, valE holds 0xF8, cc_out unchanged; raise out_ready -> consumed, next op accepted that same cycle.
- cc_hold=1 on OPq xor aluA=aluB=0xFF -> valE=0, cc_out unchanged. Illegal OPq ifun=7 -> out_err=1, valE=0, cc_out unchanged.
- Reset mid-operation: out_valid=1 with out_ready=0, assert rst one cycle -> out_valid=0, cc_out=3'b100, pending result lost.
